// File: rtl/program_counter_pkg.sv
// Datapath-wide definitions for the fetch address, shared by the program counter,
// next-PC mux and instruction memory.
package program_counter_pkg;

    localparam int PC_WIDTH = 16;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET_VECTOR = 16'h0000;

endpackage : program_counter_pkg

// File: rtl/program_counter.sv
// Fetch-address register: loads the next-PC value every rising edge unless halted,
// and is forced to the reset vector asynchronously.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC_in,
    input  logic             halt_sig,
    output logic [WIDTH-1:0] PC_out
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    // NOTE: pc_d gets its default before any condition, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d = pc_q;
        if (!halt_sig) begin
            pc_d = PC_in;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_out = pc_q;

    // Once out of reset the fetch address must always be a known value.
    a_pc_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(PC_out))
        else $error("PC_out is unknown outside reset");

    a_hold_when_halted: assert property (@(posedge clk) disable iff (rst) halt_sig |=> $stable(PC_out))
        else $error("PC_out changed across a halted edge");

    c_halt_entry:      cover property (@(posedge clk) disable iff (rst) !halt_sig ##1 halt_sig);
    c_halt_exit:       cover property (@(posedge clk) disable iff (rst) halt_sig ##1 !halt_sig);
    c_reset_in_halt:   cover property (@(posedge clk) halt_sig && rst);

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, load, halt, async reset, reset/halt
// priority and boundary addresses, each with hand-computed expectations.
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic [15:0] PC_in;
    logic        halt_sig;
    logic [15:0] PC_out;

    int checks = 0;
    int errors = 0;

    program_counter dut (
        .clk      (clk),
        .rst      (rst),
        .PC_in    (PC_in),
        .halt_sig (halt_sig),
        .PC_out   (PC_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        halt_sig = 1'b0;
        PC_in    = 16'h0004;
        #1;
        checks++;
        if (PC_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_immediate: PC_out=%h required=0000", PC_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PC_out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_held[%0d]: PC_out=%h required=0000", i, PC_out);
            end
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        rst   = 1'b0;
        PC_in = 16'h0004;
        tick();
        checks++;
        if (PC_out !== 16'h0004) begin
            errors++;
            $display("FAIL load_first: PC_out=%h required=0004", PC_out);
        end
        @(negedge clk);
        PC_in = 16'h000A;
        tick();
        checks++;
        if (PC_out !== 16'h000A) begin
            errors++;
            $display("FAIL load_second: PC_out=%h required=000a", PC_out);
        end
    endtask

    task automatic test_halt();
        @(negedge clk);
        PC_in = 16'h0004;
        tick();
        checks++;
        if (PC_out !== 16'h0004) begin
            errors++;
            $display("FAIL halt_setup: PC_out=%h required=0004", PC_out);
        end
        @(negedge clk);
        halt_sig = 1'b1;
        PC_in    = 16'h000A;
        #1;
        checks++;
        if (PC_out !== 16'h0004) begin
            errors++;
            $display("FAIL halt_between_edges: PC_out=%h required=0004", PC_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PC_out !== 16'h0004) begin
                errors++;
                $display("FAIL halt_hold[%0d]: PC_out=%h required=0004", i, PC_out);
            end
            @(negedge clk);
            PC_in = (i == 1) ? 16'h0055 : 16'h000A;
        end
        PC_in    = 16'h000A;
        halt_sig = 1'b0;
        tick();
        checks++;
        if (PC_out !== 16'h000A) begin
            errors++;
            $display("FAIL halt_resume: PC_out=%h required=000a", PC_out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst   = 1'b1;
        PC_in = 16'h0020;
        #1;
        checks++;
        if (PC_out !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_immediate: PC_out=%h required=0000", PC_out);
        end
        tick();
        checks++;
        if (PC_out !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_held: PC_out=%h required=0000", PC_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (PC_out !== 16'h0020) begin
            errors++;
            $display("FAIL async_reset_release: PC_out=%h required=0020", PC_out);
        end
    endtask

    task automatic test_reset_vs_halt();
        @(negedge clk);
        rst      = 1'b1;
        halt_sig = 1'b1;
        PC_in    = 16'h1234;
        #1;
        checks++;
        if (PC_out !== 16'h0000) begin
            errors++;
            $display("FAIL rst_halt_immediate: PC_out=%h required=0000", PC_out);
        end
        tick();
        checks++;
        if (PC_out !== 16'h0000) begin
            errors++;
            $display("FAIL rst_halt_edge: PC_out=%h required=0000", PC_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (PC_out !== 16'h0000) begin
                errors++;
                $display("FAIL rst_release_halted[%0d]: PC_out=%h required=0000", i, PC_out);
            end
        end
        @(negedge clk);
        halt_sig = 1'b0;
        tick();
        checks++;
        if (PC_out !== 16'h1234) begin
            errors++;
            $display("FAIL rst_halt_resume: PC_out=%h required=1234", PC_out);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] vals [4];
        vals = '{16'hFFFF, 16'h0000, 16'h8001, 16'h7FFF};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            PC_in = vals[i];
            tick();
            checks++;
            if (PC_out !== vals[i]) begin
                errors++;
                $display("FAIL boundary[%0d]: PC_out=%h required=%h", i, PC_out, vals[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [5];
        vals = '{16'h0100, 16'h0102, 16'h0104, 16'h0F00, 16'h0F02};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            PC_in = vals[i];
            tick();
            checks++;
            if (PC_out !== vals[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: PC_out=%h required=%h", i, PC_out, vals[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_halt();
        test_async_reset();
        test_reset_vs_halt();
        test_boundary();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_program_counter
